mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: LEN_WIDTH, default 16, width of the word-count input and internal index.
REQ-002 Port: clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge; asserted when 0.
REQ-004 Port: start  input  1  request to begin a copy; sampled only in IDLE.
REQ-005 Port: src_addr  input  32  byte address of the first source word.
REQ-006 Port: dst_addr  input  32  byte address of the first destination word.
REQ-007 Port: len  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-008 Port: busy  output  1  high while in READ or WRITE.
REQ-009 Port: done  output  1  one-cycle pulse when a copy completes.
REQ-010 Port: addr  output  32  memory byte address.
REQ-011 Port: din  output  32  write data to memory.
REQ-012 Port: mem_read  output  1  memory read enable.
REQ-013 Port: mem_write  output  1  memory write enable.
REQ-014 Port: dout  input  32  asynchronous memory read data, valid in the same cycle as mem_read.

Function
REQ-015 States SHALL be IDLE, READ, WRITE, DONE; all outputs SHALL be decoded from state and registers only (Moore).
REQ-016 In IDLE with start=1 at a clk edge, the block SHALL latch src_addr, dst_addr, len, clear index to 0, and go to READ, or to DONE if len=0.
REQ-017 start SHALL be ignored in READ, WRITE and DONE; input changes after the start edge SHALL NOT affect the copy in progress.
REQ-018 READ: mem_read=1, mem_write=0, addr = src_q + index*4 (mod 2^32); at the clk edge dout SHALL be captured into the data register and state SHALL go to WRITE.
REQ-019 WRITE: mem_write=1, mem_read=0, addr = dst_q + index*4 (mod 2^32), din = data register; at the clk edge index SHALL increment, and state SHALL go to DONE if index+1 == len_q, else READ.
REQ-020 DONE: done=1 for exactly one cycle, busy=0; next state SHALL be IDLE unconditionally.
REQ-021 In IDLE and DONE: mem_read=0, mem_write=0, addr=0, din=0.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle.
REQ-023 Copy order SHALL be ascending word index, one word per READ+WRITE pair: 2 cycles/word; done SHALL be high in the cycle 2*len+1 edges after the start edge (1 edge for len=0).
REQ-024 Overlapping regions SHALL be copied strictly in ascending order with no special handling (a destination write is visible to later source reads).
REQ-025 Address low two bits SHALL be passed through unchanged; offset arithmetic SHALL wrap modulo 2^32.
REQ-026 Maximum copy length SHALL be 2^LEN_WIDTH - 1 words; index SHALL be LEN_WIDTH bits wide.

Reset
REQ-027 When reset=0 at a clk edge, state SHALL go to IDLE and the index, data, src_q, dst_q and len_q registers SHALL clear to 0, regardless of current state.
REQ-028 During and after reset: busy=0, done=0, mem_read=0, mem_write=0, addr=0, din=0.
REQ-029 Reset asserted mid-copy SHALL abort the copy with no further memory write and no done pulse; words already written SHALL remain in memory.
REQ-030 A start held high during the reset edge SHALL NOT be accepted; start is first accepted at the first edge with reset=1.

Verification
REQ-031 Basic: mem[0x40..0x43]=A,B,C,D; start, src=0x100, dst=0x200, len=4 -> mem[0x80..0x83]=A,B,C,D; done pulses 9 edges after start; busy high for 8 cycles.
REQ-032 Zero length: start, len=0 -> no mem_read/mem_write pulses; done high in the cycle following the start edge; memory unchanged.
REQ-033 Overlap: mem[0..3]=1,2,3,4; src=0x0, dst=0x4, len=3 -> mem[0..3]=1,1,1,1.
REQ-034 Ignored start: start re-pulsed with new args during a len=4 copy -> first copy completes unchanged; exactly one done pulse.
REQ-035 Reset mid-copy: reset=0 in the WRITE cycle of word 2 of a len=4 copy -> dst words 0,1 written; words 2,3 untouched; outputs 0; no done pulse.
REQ-036 Wrap: src=0xFFFFFFF8, len=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one READ then one WRITE cycle per 32-bit word.
// All outputs are registered and computed from the next state and next register values.
module mem_copy_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          addr,
    output logic [31:0]          din,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [31:0]          dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] index_q, index_d;
    logic [31:0]          data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          din_q, din_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          offset_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        index_d = index_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    index_d = '0;
                    state_d = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                data_d  = dout;
                state_d = WRITE;
            end
            WRITE: begin
                index_d = index_q + 1'b1;
                state_d = (index_d == len_q) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from where the FSM is heading.
        offset_d    = 32'(index_d) << 2;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        addr_d      = '0;
        din_d       = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_d)
            READ: begin
                busy_d     = 1'b1;
                mem_read_d = 1'b1;
                addr_d     = src_d + offset_d;
            end
            WRITE: begin
                busy_d      = 1'b1;
                mem_write_d = 1'b1;
                addr_d      = dst_d + offset_d;
                din_d       = data_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            index_q     <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            index_q     <= index_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign addr      = addr_q;
    assign din       = din_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a 4 KB memory model, a scoreboard of expected bus accesses,
// a table of copy vectors and hand-written sequences for ignored start and mid-copy reset.
module tb_mem_copy_engine;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_in;
    logic        busy, done, mem_read, mem_write;
    logic [31:0] addr, din, dout;

    logic [31:0] mem   [MW];
    logic [31:0] model [MW];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_val;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t exp_q[$];

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          pre_n;
        logic [31:0] pre_base;
        int          exp_edges;
        int          exp_busy;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mem_copy_engine #(.LEN_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len_in),
        .busy      (busy),
        .done      (done),
        .addr      (addr),
        .din       (din),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .dout      (dout)
    );

    assign dout = mem[addr[11:2]];

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (mem_write) mem[addr[11:2]] <= din;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Bus monitor: every access must match the next scoreboard entry.
    always @(negedge clk) begin
        acc_t e;
        check("rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
        if (mem_read || mem_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_access", {31'd0, mem_write, addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("acc_kind", {63'd0, mem_write}, {63'd0, e.wr});
                check("acc_addr", {32'd0, addr}, {32'd0, e.addr});
                if (e.wr) check("wr_data", {32'd0, din}, {32'd0, e.data});
                $display("access %s addr=%08h din=%08h", mem_write ? "WR" : "RD", addr, din);
            end
        end else begin
            check("idle_bus_zero", {addr, din}, 64'd0);
        end
    end

    task automatic load_word(input int idx, input logic [31:0] val);
        ld_en  = 1'b1;
        ld_idx = 10'(idx);
        ld_val = val;
        model[idx] = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Reference copy: ascending order, writes visible to later reads.
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] a, d, v;
        for (int i = 0; i < n; i++) begin
            a = src + 32'(i * 4);
            d = dst + 32'(i * 4);
            v = model[a[11:2]];
            exp_q.push_back('{wr: 1'b0, addr: a, data: 32'd0});
            exp_q.push_back('{wr: 1'b1, addr: d, data: v});
            model[d[11:2]] = v;
        end
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== model[i]) bad++;
        check(name, 64'(bad), 64'd0);
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input bit repulse, input int exp_edges, input int exp_busy,
                            input string name);
        int edges, busy_n, pulses;
        bit seen;
        push_copy(src, dst, n);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        len_in   = 16'(n);
        @(posedge clk); #1;
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len_in   = 16'($urandom);
        edges = 1; busy_n = 0; seen = 0;
        while (edges < exp_edges + 20) begin
            if (repulse && edges == 3) begin
                start = 1'b1; src_addr = 32'h0; dst_addr = 32'h40; len_in = 16'd2;
            end
            if (repulse && edges == 4) start = 1'b0;
            if (done) begin seen = 1; break; end
            if (busy) busy_n++;
            @(posedge clk); #1;
            edges++;
        end
        check({name, "_done_edges"}, seen ? 64'(edges) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_edges));
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check({name, "_quiet_after"}, 64'(pulses), 64'd0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        compare_mem({name, "_mem"});
        $display("copy %s src=%08h dst=%08h len=%0d edges=%0d busy=%0d", name, src, dst, n, edges, busy_n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] a;
        reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_in = '0;
        ld_en = 1'b0; ld_idx = '0; ld_val = '0;

        vecs[0] = '{32'h100,      32'h200, 4, 4, 32'hA, 9,  8};
        vecs[1] = '{32'h500,      32'h600, 0, 0, 32'h0, 1,  0};
        vecs[2] = '{32'h0,        32'h4,   3, 4, 32'h1, 7,  6};
        vecs[3] = '{32'hFFFFFFF8, 32'h300, 3, 0, 32'h0, 7,  6};
        vecs[4] = '{32'h702,      32'h803, 5, 0, 32'h0, 11, 10};
        vecs[5] = '{32'h900,      32'h880, 1, 0, 32'h0, 3,  2};

        @(posedge clk); #1;
        for (int i = 0; i < MW; i++) load_word(i, 32'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_addr", {32'd0, addr}, 64'd0);
        check("rst_din", {32'd0, din}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            base = int'(vecs[v].src[11:2]);
            for (int i = 0; i < vecs[v].pre_n; i++)
                load_word((base + i) % MW, vecs[v].pre_base + 32'(i));
            for (int i = 0; i < vecs[v].len; i++) begin
                a = vecs[v].src + 32'(i * 4);
                if (vecs[v].pre_n == 0) load_word(int'(a[11:2]), $urandom);
            end
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0,
                     vecs[v].exp_edges, vecs[v].exp_busy, $sformatf("vec%0d", v));
            if (v == 0)
                for (int i = 0; i < 4; i++)
                    check("basic_dst", {32'd0, mem[32'h80 + i]}, 64'(32'hA + i));
            if (v == 2)
                for (int i = 0; i < 4; i++)
                    check("overlap_ones", {32'd0, mem[i]}, 64'd1);
        end

        // Start re-pulsed with new arguments while a copy is running.
        for (int i = 0; i < 4; i++) load_word(32'hA00 / 4 + i, 32'h5000 + 32'(i));
        run_copy(32'hA00, 32'hB00, 4, 1'b1, 9, 8, "ignored_start");

        // Reset in the WRITE cycle of the second word of a four-word copy.
        for (int i = 0; i < 4; i++) load_word(32'hE00 / 4 + i, 32'h7000 + 32'(i));
        push_copy(32'hE00, 32'hF00, 2);
        start = 1'b1; src_addr = 32'hE00; dst_addr = 32'hF00; len_in = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_in_write", {62'd0, mem_write, busy}, 64'd3);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_bus", {mem_read, mem_write, addr, din} == 66'd0 ? 64'd0 : 64'd1, 64'd0);
        @(posedge clk); #1;
        check("start_in_reset_ignored", {62'd0, busy, done}, 64'd0);
        check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        compare_mem("abort_mem");
        $display("abort sequence dst[0..3]=%08h %08h %08h %08h",
                 mem[32'hF00/4], mem[32'hF00/4+1], mem[32'hF00/4+2], mem[32'hF00/4+3]);
        reset = 1'b1;
        run_copy(32'h100, 32'h180, 2, 1'b0, 5, 4, "start_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
